atm_session_ctrl: RTL
=====================

// Module: atm_session_ctrl
// PURPOSE
//  Session sequencer in front of the ATM transaction core. Tracks card insertion, PIN
//  attempts with per-account lockout, menu selection and inactivity timeout. Issues one
//  operation at a time to the core over a req/done handshake.
//  Sits between the terminal front end (keypad/card reader) and the ATM core datapath.
// PARAMETERS
//  MAX_TRIES    3     wrong PINs before the account is locked (1..7)
//  TIMEOUT_CYC  1000  idle cycles in PIN/MENU before forced eject (>=2)
//  NUM_ACC      16    accounts tracked by the lock table; acc_num width is clog2(NUM_ACC)=4
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   synchronous, active-low reset
//  card_in      in   1   card present (level)
//  acc_num      in   4   account on card; valid while card_in=1
//  pin_valid    in   1   1-cycle strobe: PIN entered
//  pin_ok       in   1   PIN compare result, sampled only with pin_valid
//  op_valid     in   1   menu selection strobe
//  op_code      in   3   0 EXIT, 1 BALANCE, 2 WITHDRAW, 3 DEPOSIT, 4 CHANGE_PIN, 5-7 illegal
//  op_ready     out  1   1 iff state==MENU
//  core_req     out  1   request to core; held until core_done
//  core_op      out  3   op to core; stable while core_req=1
//  core_acc     out  4   latched session account; stable while core_req=1
//  core_done    in   1   1-cycle completion strobe from core
//  core_err     in   1   core error (e.g. insufficient funds), valid with core_done
//  current_state out 3   encoded FSM state
//  last_err     out  1   core_err captured at last core_done; cleared at session start
//  eject        out  1   1-cycle pulse on entering EJECT
//  timeout      out  1   1-cycle pulse when inactivity forces eject
//  acc_locked   out  1   1-cycle pulse: card refused or account just locked
//  bad_op       out  1   1-cycle pulse: illegal op_code in MENU
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, lock table=0, tries=0, timer=0, all outputs 0.
//  States: IDLE=0, PIN=1, MENU=2, BUSY=3, EJECT=4; 5-7 unreachable, recover to IDLE.
//  IDLE : card_in=1 and lock[acc_num]=0 -> latch acc, tries=0, last_err=0 -> PIN.
//         card_in=1 and lock[acc_num]=1 -> acc_locked pulse -> EJECT.
//  PIN  : pin_valid&pin_ok -> MENU. pin_valid&!pin_ok -> tries+1; when tries+1==MAX_TRIES:
//         set lock[acc], acc_locked pulse -> EJECT.
//  MENU : op_valid: EXIT -> EJECT; 1-4 -> BUSY with core_req=1, core_op=op_code
//         (registered, 1 cycle after op_valid); 5-7 -> bad_op pulse, stay MENU.
//  BUSY : core_req held. core_done -> core_req=0, last_err=core_err, -> MENU,
//         or -> EJECT if card_in fell during BUSY (remembered in a sticky flag).
//         core_done outside BUSY is ignored.
//  EJECT: eject pulses on entry only; stay until card_in=0, then IDLE (no re-entry on same card).
//  card_in=0 in PIN or MENU -> EJECT next cycle; in BUSY the core transaction is never aborted.
//  Timer: cleared on state change, pin_valid, op_valid; counts only in PIN/MENU; when it
//   reaches TIMEOUT_CYC-1 -> timeout pulse -> EJECT. Frozen in BUSY, IDLE and EJECT.
//  Priority same cycle: card removal > pin_valid/op_valid > timeout.
//  Lock bits are sticky until reset; no unlock path.
//  Latency: event at edge N, state/outputs change at edge N+1; all outputs are registered.
// STRUCTURE
//  atm_pkg.vh (shared header): state encodings, op_code constants, ACC_W=4, OP_W=3;
//   also used by the ATM core and benches.
//  Sub-module atm_idle_timer: param TIMEOUT_CYC; in clk, rst_n, clr, en; out expire.
//  Lock table: NUM_ACC-bit register, local to this block.
// TESTING
//  1 Card acc=5, pin_ok on 1st try, op=1, core_done 3 cyc later, op=0
//    -> states 0,1,2,3,2,4; core_op=1, core_acc=5; eject pulse; IDLE after card_in=0.
//  2 acc=7, three wrong PINs -> acc_locked pulse, lock[7]=1, EJECT; reinsert acc=7
//    -> immediate acc_locked + EJECT, never PIN; acc=8 still reaches PIN.
//  3 In MENU no input for TIMEOUT_CYC cycles -> timeout pulse exactly at cycle TIMEOUT_CYC-1, EJECT.
//  4 op=2 with core_err=1 at core_done -> last_err=1, back in MENU; new session clears last_err.
//  5 card_in drops in BUSY -> core_req held until core_done, then EJECT directly.
//  6 op_code=6 in MENU -> bad_op pulse, no core_req; rst_n=0 mid-BUSY -> all outputs 0 next edge.

Source files
------------

// File: rtl/atm_session_ctrl_pkg.sv
// Shared types and constants for the ATM session sequencer: state encodings,
// menu operation codes and field widths.
package atm_session_ctrl_pkg;

  localparam int ACC_W = 4;
  localparam int OP_W  = 3;
  localparam int TRY_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PIN   = 3'd1,
    ST_MENU  = 3'd2,
    ST_BUSY  = 3'd3,
    ST_EJECT = 3'd4
  } state_e;

  localparam logic [OP_W-1:0] OP_EXIT       = 3'd0;
  localparam logic [OP_W-1:0] OP_BALANCE    = 3'd1;
  localparam logic [OP_W-1:0] OP_WITHDRAW   = 3'd2;
  localparam logic [OP_W-1:0] OP_DEPOSIT    = 3'd3;
  localparam logic [OP_W-1:0] OP_CHANGE_PIN = 3'd4;

  // True for the operations that are forwarded to the transaction core.
  function automatic logic is_core_op(input logic [OP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_BALANCE, OP_WITHDRAW, OP_DEPOSIT, OP_CHANGE_PIN: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Terminal-side and core-side signals of the session sequencer. The slave
// modport is the sequencer; the master modport is front end plus core.
interface atm_session_ctrl_if;
  import atm_session_ctrl_pkg::*;

  logic             card_in;
  logic [ACC_W-1:0] acc_num;
  logic             pin_valid;
  logic             pin_ok;
  logic             op_valid;
  logic [OP_W-1:0]  op_code;
  logic             op_ready;
  logic             core_req;
  logic [OP_W-1:0]  core_op;
  logic [ACC_W-1:0] core_acc;
  logic             core_done;
  logic             core_err;
  logic [2:0]       current_state;
  logic             last_err;
  logic             eject;
  logic             timeout;
  logic             acc_locked;
  logic             bad_op;

  modport master (
    output card_in, acc_num, pin_valid, pin_ok, op_valid, op_code,
           core_done, core_err,
    input  op_ready, core_req, core_op, core_acc, current_state,
           last_err, eject, timeout, acc_locked, bad_op
  );

  modport slave (
    input  card_in, acc_num, pin_valid, pin_ok, op_valid, op_code,
           core_done, core_err,
    output op_ready, core_req, core_op, core_acc, current_state,
           last_err, eject, timeout, acc_locked, bad_op
  );

endinterface

// File: rtl/atm_session_ctrl_idle_timer.sv
// Inactivity counter: counts while enabled, restarts on clr, and flags
// expire on the cycle the count sits at TIMEOUT_CYC-1.
module atm_session_ctrl_idle_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC);

  logic [CW-1:0] count_q, count_d;

  assign expire = en && (count_q == CW'(TIMEOUT_CYC - 1));

  // Holds at the terminal count so a stalled consumer never sees a wrap.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expire) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// Session sequencer between the terminal front end and the ATM transaction
// core: card/PIN handling with per-account lockout, menu dispatch, idle eject.
module atm_session_ctrl
  import atm_session_ctrl_pkg::*;
#(
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int NUM_ACC     = 16
) (
  input logic               clk,
  input logic               rst_n,
  atm_session_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [TRY_W-1:0]   tries_inc;
  logic [NUM_ACC-1:0] lock_q, lock_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic               last_err_q, last_err_d;
  logic               card_gone_q, card_gone_d;
  logic               timeout_q, timeout_d;
  logic               acc_locked_q, acc_locked_d;
  logic               bad_op_q, bad_op_d;
  logic               eject_q, op_ready_q, core_req_q;
  logic               timer_clr, timer_en, timer_expire;

  assign tries_inc = tries_q + TRY_W'(1);

  assign timer_en  = (state_q == ST_PIN) || (state_q == ST_MENU);
  assign timer_clr = (state_d != state_q) || bus.pin_valid || bus.op_valid;

  atm_session_ctrl_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (timer_expire)
  );

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    tries_d      = tries_q;
    lock_d       = lock_q;
    op_d         = op_q;
    last_err_d   = last_err_q;
    card_gone_d  = card_gone_q;
    timeout_d    = 1'b0;
    acc_locked_d = 1'b0;
    bad_op_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.card_in) begin
          if (lock_q[bus.acc_num]) begin
            acc_locked_d = 1'b1;
            state_d      = ST_EJECT;
          end else begin
            acc_d      = bus.acc_num;
            tries_d    = '0;
            last_err_d = 1'b0;
            state_d    = ST_PIN;
          end
        end
      end

      ST_PIN: begin
        if (!bus.card_in) begin
          state_d = ST_EJECT;
        end else if (bus.pin_valid) begin
          if (bus.pin_ok) begin
            state_d = ST_MENU;
          end else begin
            tries_d = tries_inc;
            if (tries_inc == TRY_W'(MAX_TRIES)) begin
              lock_d[acc_q] = 1'b1;
              acc_locked_d  = 1'b1;
              state_d       = ST_EJECT;
            end
          end
        end else if (timer_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_EJECT;
        end
      end

      ST_MENU: begin
        if (!bus.card_in) begin
          state_d = ST_EJECT;
        end else if (bus.op_valid) begin
          if (bus.op_code == OP_EXIT) begin
            state_d = ST_EJECT;
          end else if (is_core_op(bus.op_code)) begin
            op_d        = bus.op_code;
            card_gone_d = 1'b0;
            state_d     = ST_BUSY;
          end else begin
            bad_op_d = 1'b1;
          end
        end else if (timer_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_EJECT;
        end
      end

      // The core transaction always runs to completion; a pulled card is
      // only remembered and acted on once core_done arrives.
      ST_BUSY: begin
        if (!bus.card_in) begin
          card_gone_d = 1'b1;
        end
        if (bus.core_done) begin
          last_err_d = bus.core_err;
          state_d    = (card_gone_q || !bus.card_in) ? ST_EJECT : ST_MENU;
        end
      end

      ST_EJECT: begin
        if (!bus.card_in) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      tries_q      <= '0;
      lock_q       <= '0;
      op_q         <= '0;
      last_err_q   <= 1'b0;
      card_gone_q  <= 1'b0;
      timeout_q    <= 1'b0;
      acc_locked_q <= 1'b0;
      bad_op_q     <= 1'b0;
      eject_q      <= 1'b0;
      op_ready_q   <= 1'b0;
      core_req_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      tries_q      <= tries_d;
      lock_q       <= lock_d;
      op_q         <= op_d;
      last_err_q   <= last_err_d;
      card_gone_q  <= card_gone_d;
      timeout_q    <= timeout_d;
      acc_locked_q <= acc_locked_d;
      bad_op_q     <= bad_op_d;
      eject_q      <= (state_d == ST_EJECT) && (state_q != ST_EJECT);
      op_ready_q   <= (state_d == ST_MENU);
      core_req_q   <= (state_d == ST_BUSY);
    end
  end

  assign bus.current_state = state_q;
  assign bus.op_ready      = op_ready_q;
  assign bus.core_req      = core_req_q;
  assign bus.core_op       = op_q;
  assign bus.core_acc      = acc_q;
  assign bus.last_err      = last_err_q;
  assign bus.eject         = eject_q;
  assign bus.timeout       = timeout_q;
  assign bus.acc_locked    = acc_locked_q;
  assign bus.bad_op        = bad_op_q;

endmodule
